// File: rtl/serial_cmd_frame_parser.sv
// Byte-stream command framer: hunts SOF, assembles CMD/ADDR/DATA/XOR-checksum frames,
// validates them and presents one command at a time on a valid/ready handshake.
module serial_cmd_frame_parser #(
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int          DATA_BYTES     = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd500000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_byte_received,
  input  logic                    rx_err,
  output logic                    rx_read,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [7:0]              cmd_code,
  output logic [7:0]              cmd_addr,
  output logic [8*DATA_BYTES-1:0] cmd_data,
  output logic                    frame_err,
  output logic [2:0]              frame_err_code,
  output logic [15:0]             frames_ok,
  output logic [15:0]             frames_bad
);

  localparam int         DW       = 8 * DATA_BYTES;
  localparam logic [1:0] LAST_IDX = 2'(DATA_BYTES - 1);
  localparam logic [2:0] ERR_CSUM = 3'd1;
  localparam logic [2:0] ERR_CMD  = 3'd2;
  localparam logic [2:0] ERR_TMO  = 3'd3;
  localparam logic [2:0] ERR_RX   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_CMD  = 3'd1,
    ST_GET_ADDR = 3'd2,
    ST_GET_DATA = 3'd3,
    ST_GET_CSUM = 3'd4,
    ST_CHECK    = 3'd5,
    ST_PRESENT  = 3'd6
  } state_t;

  function automatic logic known_cmd(input logic [7:0] code);
    return (code == 8'h01) || (code == 8'h02);
  endfunction

  // First payload byte ends up in the MSBs after DATA_BYTES shifts.
  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] cur, input logic [7:0] b);
    logic [DW+7:0] wide;
    wide = {cur, b};
    return wide[DW-1:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t          state_r, state_next_s;
  logic            rx_read_prev_r;
  logic [7:0]      acc_r, cmd_asm_r, addr_asm_r, csum_r;
  logic [DW-1:0]   data_asm_r;
  logic [1:0]      byte_idx_r;
  logic [23:0]     tmo_cnt_r;
  logic            cmd_valid_r, frame_err_r;
  logic [7:0]      cmd_code_r, cmd_addr_r;
  logic [DW-1:0]   cmd_data_r;
  logic [2:0]      frame_err_code_r;
  logic [15:0]     frames_ok_r, frames_bad_r;

  logic            in_get_s, rx_err_hit_s, tmo_hit_s, pop_s;
  logic            csum_bad_s, cmd_bad_s, err_s, accept_s;
  logic [2:0]      err_code_s;

  // Pop/abort/accept qualification; rx_read must be combinational so the byte is captured in the pop cycle.
  always_comb begin
    in_get_s     = (state_r == ST_GET_CMD) || (state_r == ST_GET_ADDR) ||
                   (state_r == ST_GET_DATA) || (state_r == ST_GET_CSUM);
    rx_err_hit_s = in_get_s && rx_err;
    tmo_hit_s    = in_get_s && !rx_err && (tmo_cnt_r == (TIMEOUT_CYCLES - 24'd1));
    pop_s        = !rst && ((state_r == ST_IDLE) || in_get_s) && rx_byte_received &&
                   !rx_read_prev_r && !rx_err_hit_s && !tmo_hit_s;
    csum_bad_s   = (state_r == ST_CHECK) && (csum_r != acc_r);
    cmd_bad_s    = (state_r == ST_CHECK) && !csum_bad_s && !known_cmd(cmd_asm_r);
    err_s        = rx_err_hit_s || tmo_hit_s || csum_bad_s || cmd_bad_s;
    accept_s     = (state_r == ST_PRESENT) && cmd_valid_r && cmd_ready;
  end

  // Error code selection, highest priority first.
  always_comb begin
    err_code_s = 3'd0;
    if (rx_err_hit_s) begin
      err_code_s = ERR_RX;
    end else if (tmo_hit_s) begin
      err_code_s = ERR_TMO;
    end else if (csum_bad_s) begin
      err_code_s = ERR_CSUM;
    end else if (cmd_bad_s) begin
      err_code_s = ERR_CMD;
    end else begin
      err_code_s = 3'd0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    if (rx_err_hit_s || tmo_hit_s) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:     state_next_s = (pop_s && (rx_data == SOF_BYTE)) ? ST_GET_CMD : ST_IDLE;
        ST_GET_CMD:  state_next_s = pop_s ? ST_GET_ADDR : ST_GET_CMD;
        ST_GET_ADDR: state_next_s = pop_s ? ST_GET_DATA : ST_GET_ADDR;
        ST_GET_DATA: state_next_s = (pop_s && (byte_idx_r == LAST_IDX)) ? ST_GET_CSUM : ST_GET_DATA;
        ST_GET_CSUM: state_next_s = pop_s ? ST_CHECK : ST_GET_CSUM;
        ST_CHECK:    state_next_s = err_s ? ST_IDLE : ST_PRESENT;
        ST_PRESENT:  state_next_s = accept_s ? ST_IDLE : ST_PRESENT;
        default:     state_next_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Frame assembly, timeout counter, presented outputs and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_read_prev_r   <= 1'b0;
      acc_r            <= 8'h00;
      cmd_asm_r        <= 8'h00;
      addr_asm_r       <= 8'h00;
      csum_r           <= 8'h00;
      data_asm_r       <= '0;
      byte_idx_r       <= 2'd0;
      tmo_cnt_r        <= 24'd0;
      cmd_valid_r      <= 1'b0;
      frame_err_r      <= 1'b0;
      cmd_code_r       <= 8'h00;
      cmd_addr_r       <= 8'h00;
      cmd_data_r       <= '0;
      frame_err_code_r <= 3'd0;
      frames_ok_r      <= 16'd0;
      frames_bad_r     <= 16'd0;
    end else begin
      rx_read_prev_r <= pop_s;
      frame_err_r    <= err_s;

      if (pop_s || !in_get_s) begin
        tmo_cnt_r <= 24'd0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + 24'd1;
      end

      if (pop_s) begin
        case (state_r)
          ST_IDLE: begin
            acc_r      <= 8'h00;
            byte_idx_r <= 2'd0;
          end
          ST_GET_CMD: begin
            cmd_asm_r <= rx_data;
            acc_r     <= acc_r ^ rx_data;
          end
          ST_GET_ADDR: begin
            addr_asm_r <= rx_data;
            acc_r      <= acc_r ^ rx_data;
          end
          ST_GET_DATA: begin
            data_asm_r <= shift_in(data_asm_r, rx_data);
            acc_r      <= acc_r ^ rx_data;
            byte_idx_r <= byte_idx_r + 2'd1;
          end
          ST_GET_CSUM: csum_r <= rx_data;
          default: acc_r <= acc_r;
        endcase
      end

      if (err_s) begin
        frame_err_code_r <= err_code_s;
        frames_bad_r     <= sat_inc(frames_bad_r);
      end

      if ((state_r == ST_CHECK) && !err_s) begin
        cmd_valid_r <= 1'b1;
        cmd_code_r  <= cmd_asm_r;
        cmd_addr_r  <= addr_asm_r;
        cmd_data_r  <= data_asm_r;
      end

      if (accept_s) begin
        cmd_valid_r <= 1'b0;
        frames_ok_r <= sat_inc(frames_ok_r);
      end
    end
  end

  assign rx_read        = pop_s;
  assign cmd_valid      = cmd_valid_r;
  assign cmd_code       = cmd_code_r;
  assign cmd_addr       = cmd_addr_r;
  assign cmd_data       = cmd_data_r;
  assign frame_err      = frame_err_r;
  assign frame_err_code = frame_err_code_r;
  assign frames_ok      = frames_ok_r;
  assign frames_bad     = frames_bad_r;

endmodule
